// File: rtl/rs_16_16_11_approx_sub_seq.sv
// rs_16_16_11_approx_sub_seq: chunk-serial approximate ripple-borrow subtractor with valid/ready handshakes
module rs_16_16_11_approx_sub_seq #(
  parameter int WIDTH  = 16,
  parameter int APPROX = 11,
  parameter int CHUNK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Out
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   out_q;
  logic             bor_q, bor_d, in_ready_q, out_valid_q;
  logic [KW-1:0]    k_q;
  logic [CHUNK-1:0] xs_d, ys_d, dif_d;
  assign xs_d = a_q[int'(k_q)*CHUNK +: CHUNK];
  assign ys_d = b_q[int'(k_q)*CHUNK +: CHUNK];
  // Cell type follows the global bit index, so one chunk may mix both kinds.
  always_comb begin
    bor_d = bor_q;
    dif_d = '0;
    for (int j = 0; j < CHUNK; j++) begin
      dif_d[j] = (int'(k_q)*CHUNK + j < APPROX) ? xs_d[j] : xs_d[j] ^ ys_d[j] ^ bor_d;
      bor_d    = (int'(k_q)*CHUNK + j < APPROX) ? ys_d[j]
               : (~xs_d[j] & ys_d[j]) | (~xs_d[j] & bor_d) | (ys_d[j] & bor_d);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      bor_q       <= 1'b0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q        <= IN1;
          b_q        <= IN2;
          bor_q      <= 1'b0;
          k_q        <= '0;
          in_ready_q <= 1'b0;
          state_q    <= BUSY;
        end
        BUSY: begin
          out_q[int'(k_q)*CHUNK +: CHUNK] <= dif_d;
          bor_q <= bor_d;
          k_q   <= k_q + 1'b1;
          if (k_q == KW'(N - 1)) begin
            out_q[WIDTH] <= bor_d;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Out       = out_q;
endmodule

// File: tb/tb_rs_16_16_11_approx_sub_seq.sv
// tb_rs_16_16_11_approx_sub_seq: directed + random scoreboard bench for default and exact (APPROX=0) builds
module tb_rs_16_16_11_approx_sub_seq;
  logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in1 = '0, in2 = '0;
  logic        in_ready, out_valid, in_ready0, out_valid0;
  logic [16:0] out, out0;
  int          n_vec = 0, n_err = 0;
  logic [16:0] sb[$];
  logic [16:0] sb0[$];
  always #5 clk = ~clk;
  rs_16_16_11_approx_sub_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .IN1(in1), .IN2(in2),
    .out_valid(out_valid), .out_ready(out_ready), .Out(out));
  rs_16_16_11_approx_sub_seq #(.APPROX(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .IN1(in1), .IN2(in2),
    .out_valid(out_valid0), .out_ready(out_ready), .Out(out0));
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    logic        b = 1'b0;
    logic [15:0] d;
    for (int i = 0; i < 16; i++) begin
      if (i < 11) begin
        d[i] = x[i];
        b    = y[i];
      end else begin
        d[i] = x[i] ^ y[i] ^ b;
        b    = (~x[i] & y[i]) | (~x[i] & b) | (y[i] & b);
      end
    end
    return {b, d};
  endfunction
  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Starts at a point #1 after a posedge; returns #1 after the output handshake edge.
  task automatic xfer(input logic [15:0] a, input logic [15:0] b, input int hold);
    int edges;
    logic [16:0] held;
    chk("in_ready_before_accept", {16'd0, in_ready}, 17'd1);
    in_valid = 1'b1; in1 = a; in2 = b;
    out_ready = (hold == 0);
    sb.push_back(model(a, b));
    sb0.push_back({1'b0, a} - {1'b0, b});
    @(posedge clk); #1;
    edges = 1;
    while (!out_valid && edges < 20) begin
      in_valid = 1'($urandom_range(0, 1)); in1 = 16'($urandom); in2 = 16'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    chk("latency_edges_incl_accept", 17'(edges), 17'd5);
    chk("out_valid0_aligned", {16'd0, out_valid0}, 17'd1);
    held = out;
    for (int i = 0; i < hold; i++) begin
      in1 = 16'($urandom); in2 = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", {16'd0, out_valid}, 17'd1);
      chk("bp_out_stable", out, held);
      chk("bp_in_ready", {16'd0, in_ready}, 17'd0);
    end
    chk("result", out, sb.pop_front());
    chk("result_exact", out0, sb0.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_after_hs", {16'd0, out_valid}, 17'd0);
    chk("in_ready_after_hs", {16'd0, in_ready}, 17'd1);
  endtask
  initial begin
    rst = 1'b1; #2;
    chk("rst_in_ready", {16'd0, in_ready}, 17'd1);
    chk("rst_out_valid", {16'd0, out_valid}, 17'd0);
    chk("rst_out", out, 17'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    xfer(16'h1234, 16'h0123, 0);
    chk("dir_1234_0123", out, 17'h01234);
    xfer(16'h0800, 16'h0C00, 0);
    chk("dir_0800_0C00", out, 17'h1F800);
    xfer(16'hFFFF, 16'h0000, 0);
    chk("dir_FFFF_0000", out, 17'h0FFFF);
    xfer(16'h0000, 16'hFFFF, 0);
    xfer(16'h5A5A, 16'hA5A5, 10);
    // Abort during the second BUSY cycle.
    in_valid = 1'b1; in1 = 16'hBEEF; in2 = 16'h1234;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("abort_out_valid", {16'd0, out_valid}, 17'd0);
    chk("abort_in_ready", {16'd0, in_ready}, 17'd1);
    chk("abort_out", out, 17'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_out_valid", {16'd0, out_valid}, 17'd0);
    xfer(16'h1234, 16'h0123, 0);
    chk("post_abort_1234", out, 17'h01234);
    for (int t = 0; t < 300; t++) xfer(16'($urandom), 16'($urandom), (t % 50 == 7) ? 3 : 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
